// File: rtl/mem_xfer_pkg.sv
// Shared definitions for the two-memory transfer sequencer:
// state encoding, default memory-A address width and the derived
// memory-B address width.
package mem_xfer_pkg;

    // Sequencer states, binary encoded.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } xfer_state_t;

    // Default address width of memory A (8 words).
    localparam int A_AW_DEFAULT = 3;

    // Memory B holds one result per pair of A words, so it needs one address bit fewer.
    function automatic int b_aw_of(input int a_aw);
        return a_aw - 1;
    endfunction

endpackage

// File: rtl/xfer_phase_counter.sv
// Shadow phase counter: W-bit up-counter with synchronous clear and
// enable, wrapping modulo 2^W, plus a flag for the all-ones count.
// reset_n is synchronous and active-low.
module xfer_phase_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         terminal
);

    logic [W-1:0] count_reg;

    // Count register: reset and clear both return to zero; clear wins over enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count    = count_reg;
    assign terminal = (count_reg == {W{1'b1}});

endmodule

// File: rtl/mem_transfer_sequencer.sv
// Controller for the two-memory transfer datapath. A load phase fills
// memory A from a valid/ready producer; a transfer phase then writes one
// combined result into memory B for every pair A[2k], A[2k+1].
// Optional feature macro: MEMXFER_ABORT_EN adds Abort/Aborted, letting
// the host cancel a run during LOAD or XFER.
module mem_transfer_sequencer
    import mem_xfer_pkg::*;
#(
    parameter int A_AW = A_AW_DEFAULT,
    parameter int B_AW = b_aw_of(A_AW)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    input  logic LoadValid,
`ifdef MEMXFER_ABORT_EN
    input  logic Abort,
    output logic Aborted,
`endif
    output logic LoadReady,
    output logic WEA,
    output logic IncA,
    output logic LdA,
    output logic WEB,
    output logic IncB,
    output logic LdB,
    output logic Busy,
    output logic Done
);

    // Reject parameter combinations the datapath cannot support.
    generate
        if (A_AW < 2) begin : g_bad_a_aw
            $error("mem_transfer_sequencer: A_AW must be at least 2");
        end
        if (B_AW != A_AW - 1) begin : g_bad_b_aw
            $error("mem_transfer_sequencer: B_AW must equal A_AW-1");
        end
    endgenerate

    xfer_state_t state_reg;
    xfer_state_t state_next;

    logic            sa_clear;
    logic            sa_enable;
    logic            sa_last;
    logic [A_AW-1:0] sa_count;
    logic            sb_clear;
    logic            sb_enable;
    logic            sb_last;
    logic [B_AW-1:0] sb_count;
    logic            abort_hit;

`ifdef MEMXFER_ABORT_EN
    logic aborted_reg;
    logic abort_take;

    // An abort only matters while a run is actually moving data.
    assign abort_hit  = Abort;
    assign abort_take = Abort && ((state_reg == S_LOAD) || (state_reg == S_XFER));

    // Aborted is a one-cycle registered pulse, visible in the IDLE cycle after the abort.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            aborted_reg <= 1'b0;
        end else begin
            aborted_reg <= abort_take;
        end
    end

    assign Aborted = aborted_reg;
`else
    assign abort_hit = 1'b0;
`endif

    // Shadow copy of address counter A: tracks words loaded, then words read.
    xfer_phase_counter #(
        .W(A_AW)
    ) u_sa (
        .clk      (Clk),
        .reset_n  (Reset),
        .clear    (sa_clear),
        .enable   (sa_enable),
        .count    (sa_count),
        .terminal (sa_last)
    );

    // Shadow copy of address counter B: tracks results written.
    xfer_phase_counter #(
        .W(B_AW)
    ) u_sb (
        .clk      (Clk),
        .reset_n  (Reset),
        .clear    (sb_clear),
        .enable   (sb_enable),
        .count    (sb_count),
        .terminal (sb_last)
    );

    // State register; reset always returns to IDLE, even mid-run.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_next = state_reg;
        LoadReady  = 1'b0;
        WEA        = 1'b0;
        IncA       = 1'b0;
        LdA        = 1'b0;
        WEB        = 1'b0;
        IncB       = 1'b0;
        LdB        = 1'b0;
        Busy       = 1'b1;
        Done       = 1'b0;
        sa_clear   = 1'b0;
        sa_enable  = 1'b0;
        sb_clear   = 1'b0;
        sb_enable  = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    // Point both memories at word 0 and restart the shadow counts.
                    LdA        = 1'b1;
                    LdB        = 1'b1;
                    sa_clear   = 1'b1;
                    sb_clear   = 1'b1;
                    state_next = S_LOAD;
                end
            end

            S_LOAD: begin
                LoadReady = 1'b1;
                if (abort_hit) begin
                    state_next = S_IDLE;
                end else if (LoadValid) begin
                    WEA       = 1'b1;
                    IncA      = 1'b1;
                    sa_enable = 1'b1;
                    // Last word written: counter A wraps to 0, ready for the read pass.
                    if (sa_last) begin
                        state_next = S_XFER;
                    end
                end
            end

            S_XFER: begin
                if (abort_hit) begin
                    state_next = S_IDLE;
                end else begin
                    IncA      = 1'b1;
                    sa_enable = 1'b1;
                    // On odd addresses the delay register holds A[2k] and A[2k+1] is on the read port.
                    if (sa_count[0]) begin
                        WEB       = 1'b1;
                        IncB      = 1'b1;
                        sb_enable = 1'b1;
                    end
                    if (sa_last) begin
                        state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                Done       = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // During XFER the results written so far equal half the words read so far.
    a_sb_tracks_sa: assert property (@(posedge Clk) disable iff (!Reset)
        (state_reg == S_XFER) |-> (sb_count == sa_count[A_AW-1:1]));

    // The final read cycle is also the final write into memory B.
    a_final_write: assert property (@(posedge Clk) disable iff (!Reset)
        ((state_reg == S_XFER) && sa_last && !abort_hit) |-> sb_last);

endmodule
